uart_cmd_ctrl: RTL and testbench

- Command controller sitting directly upstream of the register file, between the UART receiver/transmitter and the RF port.
- Parses byte frames from UART RX into RF write and read accesses.
- Returns read data to UART TX.
- Owns the RF address, write-data and enable signals; consumes the registered RF read data and its valid strobe.

---
 rtl/uart_cmd_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_cmd_ctrl                                                |
// | Description : Parses UART RX byte frames into register-file write/read     |
// |               accesses and returns read data to UART TX.                   |
// |               Write frame: WR_CMD, ADDR, DATA.  Read frame: RD_CMD, ADDR.  |
// |               Optional macro CTRL_TIMEOUT_EN adds an inter-byte timeout.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_cmd_ctrl #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      DEPTH          = 16,
  parameter logic [WIDTH-1:0] WR_CMD         = 8'hAA,
  parameter logic [WIDTH-1:0] RD_CMD         = 8'hBB,
  parameter int unsigned      TIMEOUT_CYCLES = 1024
) (
  input  logic             CTRL_CLK,
  input  logic             CTRL_RST,
  input  logic [WIDTH-1:0] RX_P_Data,
  input  logic             RX_D_Valid,
  input  logic [WIDTH-1:0] RF_RdData,
  input  logic             RF_Rd_Data_Valid,
  input  logic             TX_Busy,
  output logic [WIDTH-1:0] RF_Addr,
  output logic [WIDTH-1:0] RF_WrData,
  output logic             RF_Wr_en,
  output logic             RF_Rd_en,
  output logic [WIDTH-1:0] TX_P_Data,
  output logic             TX_D_Valid,
  output logic             Cmd_Error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_TX_SEND = 3'd5
  } state_e;

  // One extra bit so DEPTH itself is representable when DEPTH == 2**WIDTH.
  localparam logic [WIDTH:0] c_DEPTH = (WIDTH+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [WIDTH-1:0] rf_wrdata_q, rf_wrdata_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             rf_wr_en_q, rf_wr_en_d;
  logic             rf_rd_en_q, rf_rd_en_d;
  logic             tx_valid_q, tx_valid_d;
  logic             err_q, err_d;
  logic             addr_ok;
  logic             to_expired;

  assign addr_ok = ({1'b0, RX_P_Data} < c_DEPTH);

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned c_TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] to_cnt_q, to_cnt_d;
  logic              to_active;

  assign to_active  = state_q inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR};
  assign to_expired = to_active && !RX_D_Valid && (to_cnt_q == c_TO_LAST);

  // Inter-byte counter: zero outside partial frames, on any byte and on state entry.
  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    if (!to_active || RX_D_Valid || (state_d != state_q)) begin
      to_cnt_d = '0;
    end
  end

  // Inter-byte counter register.
  always_ff @(posedge CTRL_CLK or negedge CTRL_RST) begin
    if (!CTRL_RST) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign to_expired     = 1'b0;
  // Keeps the timeout parameter referenced when the counter is compiled out.
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Frame parser: next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    rf_addr_d   = rf_addr_q;
    rf_wrdata_d = rf_wrdata_q;
    tx_data_d   = tx_data_q;
    rf_wr_en_d  = 1'b0;
    rf_rd_en_d  = 1'b0;
    tx_valid_d  = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RX_D_Valid) begin
          if (RX_P_Data == WR_CMD)      state_d = S_WR_ADDR;
          else if (RX_P_Data == RD_CMD) state_d = S_RD_ADDR;
          else                          err_d   = 1'b1;
        end
      end
      S_WR_ADDR: begin
        if (RX_D_Valid) begin
          if (addr_ok) begin
            addr_d  = RX_P_Data;
            state_d = S_WR_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (RX_D_Valid) begin
          rf_addr_d   = addr_q;
          rf_wrdata_d = RX_P_Data;
          rf_wr_en_d  = 1'b1;
          state_d     = S_IDLE;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_Valid) begin
          if (addr_ok) begin
            rf_addr_d  = RX_P_Data;
            rf_rd_en_d = 1'b1;
            state_d    = S_RD_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        // Bytes arriving while a read is outstanding are dropped.
        err_d = RX_D_Valid;
        // RF read data is only valid alongside its strobe.
        if (RF_Rd_Data_Valid) begin
          hold_d  = RF_RdData;
          state_d = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        err_d = RX_D_Valid;
        if (!TX_Busy) begin
          tx_data_d  = hold_q;
          tx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge CTRL_CLK or negedge CTRL_RST) begin
    if (!CTRL_RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      hold_q      <= '0;
      rf_addr_q   <= '0;
      rf_wrdata_q <= '0;
      tx_data_q   <= '0;
      rf_wr_en_q  <= 1'b0;
      rf_rd_en_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      rf_addr_q   <= rf_addr_d;
      rf_wrdata_q <= rf_wrdata_d;
      tx_data_q   <= tx_data_d;
      rf_wr_en_q  <= rf_wr_en_d;
      rf_rd_en_q  <= rf_rd_en_d;
      tx_valid_q  <= tx_valid_d;
      err_q       <= err_d;
    end
  end

  assign RF_Addr    = rf_addr_q;
  assign RF_WrData  = rf_wrdata_q;
  assign RF_Wr_en   = rf_wr_en_q;
  assign RF_Rd_en   = rf_rd_en_q;
  assign TX_P_Data  = tx_data_q;
  assign TX_D_Valid = tx_valid_q;
  assign Cmd_Error  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_cmd_ctrl                                             |
// | Description : Scoreboard bench for uart_cmd_ctrl with a behavioural RF.    |
// |               Honours CTRL_TIMEOUT_EN when it is defined.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_cmd_ctrl;

  typedef struct packed {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic       CTRL_CLK         = 1'b0;
  logic       CTRL_RST         = 1'b1;
  logic [7:0] RX_P_Data        = 8'h00;
  logic       RX_D_Valid       = 1'b0;
  logic [7:0] RF_RdData        = 8'h00;
  logic       RF_Rd_Data_Valid = 1'b0;
  logic       TX_Busy          = 1'b0;
  logic [7:0] RF_Addr, RF_WrData, TX_P_Data;
  logic       RF_Wr_en, RF_Rd_en, TX_D_Valid, Cmd_Error;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  checking = 1'b0;

  ev_t        exp_wr[$], exp_rd[$], exp_tx[$], exp_err[$];
  logic [7:0] rf_mem  [16];
  logic [7:0] exp_mem [16];

  uart_cmd_ctrl #(
    .WIDTH(8), .DEPTH(16), .WR_CMD(8'hAA), .RD_CMD(8'hBB), .TIMEOUT_CYCLES(16)
  ) dut (
    .CTRL_CLK(CTRL_CLK), .CTRL_RST(CTRL_RST),
    .RX_P_Data(RX_P_Data), .RX_D_Valid(RX_D_Valid),
    .RF_RdData(RF_RdData), .RF_Rd_Data_Valid(RF_Rd_Data_Valid),
    .TX_Busy(TX_Busy),
    .RF_Addr(RF_Addr), .RF_WrData(RF_WrData),
    .RF_Wr_en(RF_Wr_en), .RF_Rd_en(RF_Rd_en),
    .TX_P_Data(TX_P_Data), .TX_D_Valid(TX_D_Valid),
    .Cmd_Error(Cmd_Error)
  );

  always #5 CTRL_CLK = ~CTRL_CLK;

  always @(posedge CTRL_CLK) cyc <= cyc + 1;

  // Register file: registered read data valid one cycle after Rd_en, zero otherwise.
  always @(posedge CTRL_CLK) begin
    if (RF_Wr_en) rf_mem[RF_Addr[3:0]] <= RF_WrData;
    RF_Rd_Data_Valid <= RF_Rd_en;
    RF_RdData        <= RF_Rd_en ? rf_mem[RF_Addr[3:0]] : 8'h00;
  end

  // Scoreboard: every DUT pulse is matched against the oldest expected event.
  always @(negedge CTRL_CLK) begin
    ev_t e;
    if (checking && CTRL_RST) begin
      if (RF_Wr_en && RF_Rd_en) begin
        n_checks++; n_fail++;
        $display("FAIL wr_rd_exclusive: both enables high at cycle %0d", cyc);
      end
      if (RF_Wr_en) begin
        n_checks++;
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: cyc=%0d addr=%02h data=%02h, required none", cyc, RF_Addr, RF_WrData);
        end else begin
          e = exp_wr.pop_front();
          if ({cyc, RF_Addr, RF_WrData} !== {e.cyc, e.a, e.d}) begin
            n_fail++;
            $display("FAIL write: got cyc=%0d addr=%02h data=%02h, required cyc=%0d addr=%02h data=%02h",
                     cyc, RF_Addr, RF_WrData, e.cyc, e.a, e.d);
          end
        end
      end
      if (RF_Rd_en) begin
        n_checks++;
        if (exp_rd.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_read: cyc=%0d addr=%02h, required none", cyc, RF_Addr);
        end else begin
          e = exp_rd.pop_front();
          if ({cyc, RF_Addr} !== {e.cyc, e.a}) begin
            n_fail++;
            $display("FAIL read: got cyc=%0d addr=%02h, required cyc=%0d addr=%02h", cyc, RF_Addr, e.cyc, e.a);
          end
        end
      end
      if (TX_D_Valid) begin
        n_checks++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tx: cyc=%0d data=%02h, required none", cyc, TX_P_Data);
        end else begin
          e = exp_tx.pop_front();
          if ({cyc, TX_P_Data} !== {e.cyc, e.d}) begin
            n_fail++;
            $display("FAIL tx: got cyc=%0d data=%02h, required cyc=%0d data=%02h", cyc, TX_P_Data, e.cyc, e.d);
          end
        end
      end
      if (Cmd_Error) begin
        n_checks++;
        if (exp_err.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_error: cyc=%0d, required none", cyc);
        end else begin
          e = exp_err.pop_front();
          if (cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL error_pulse: got cyc=%0d, required cyc=%0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n edges and settle just past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CTRL_CLK);
    #1;
  endtask

  // One-cycle RX strobe; stamp is the cycle in which a registered response appears.
  task automatic send_byte(input logic [7:0] b, output int stamp);
    RX_P_Data  = b;
    RX_D_Valid = 1'b1;
    @(posedge CTRL_CLK);
    #1;
    RX_D_Valid = 1'b0;
    stamp      = cyc;
  endtask

  task automatic push_wr(input int c, input logic [7:0] a, input logic [7:0] d);
    exp_wr.push_back('{cyc: c, a: a, d: d});
    exp_mem[a[3:0]] = d;
  endtask

  // A read produces Rd_en now and the TX byte three cycles later when TX is free.
  task automatic push_rd(input int c, input logic [7:0] a, input bit tx_free);
    exp_rd.push_back('{cyc: c, a: a, d: 8'h00});
    if (tx_free) exp_tx.push_back('{cyc: c + 3, a: 8'h00, d: exp_mem[a[3:0]]});
  endtask

  task automatic push_err(input int c);
    exp_err.push_back('{cyc: c, a: 8'h00, d: 8'h00});
  endtask

  task automatic test_reset;
    #2 CTRL_RST = 1'b0;
    #1;
    n_checks++;
    if ({RF_Addr, RF_WrData, RF_Wr_en, RF_Rd_en, TX_P_Data, TX_D_Valid, Cmd_Error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {RF_Addr, RF_WrData, RF_Wr_en, RF_Rd_en, TX_P_Data, TX_D_Valid, Cmd_Error});
    end
    tick(3);
    CTRL_RST = 1'b1;
    checking = 1'b1;
    tick(2);
    n_checks++;
    if ({RF_Addr, RF_WrData, RF_Wr_en, RF_Rd_en, TX_P_Data, TX_D_Valid, Cmd_Error} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h, required 0",
               {RF_Addr, RF_WrData, RF_Wr_en, RF_Rd_en, TX_P_Data, TX_D_Valid, Cmd_Error});
    end
  endtask

  task automatic expect_drained(input string name);
    n_checks++;
    if ({exp_wr.size(), exp_rd.size(), exp_tx.size(), exp_err.size()} !== '0) begin
      n_fail++;
      $display("FAIL %s_missing_events: pending wr=%0d rd=%0d tx=%0d err=%0d, required all 0",
               name, exp_wr.size(), exp_rd.size(), exp_tx.size(), exp_err.size());
    end
  endtask

  task automatic test_write;
    int s;
    send_byte(8'hAA, s); tick(1);
    send_byte(8'h05, s); tick(1);
    send_byte(8'h3C, s); push_wr(s, 8'h05, 8'h3C);
    tick(4);
    expect_drained("write");
    n_checks++;
    if ({RF_Addr, RF_WrData} !== 16'h053C) begin
      n_fail++;
      $display("FAIL write_hold: got %h, required 053c", {RF_Addr, RF_WrData});
    end
  endtask

  task automatic test_read;
    int s;
    send_byte(8'hBB, s); tick(1);
    send_byte(8'h05, s); push_rd(s, 8'h05, 1'b1);
    tick(6);
    expect_drained("read");
    n_checks++;
    if (TX_P_Data !== 8'h3C) begin
      n_fail++;
      $display("FAIL tx_hold: got %02h, required 3c", TX_P_Data);
    end
  endtask

  task automatic test_tx_busy;
    int s;
    send_byte(8'hAA, s); send_byte(8'h03, s); send_byte(8'hC7, s);
    push_wr(s, 8'h03, 8'hC7);
    tick(2);
    TX_Busy = 1'b1;
    send_byte(8'hBB, s); send_byte(8'h03, s); push_rd(s, 8'h03, 1'b0);
    tick(8);
    send_byte(8'h11, s); push_err(s);      // dropped while waiting on TX
    tick(11);
    TX_Busy = 1'b0;
    exp_tx.push_back('{cyc: cyc + 1, a: 8'h00, d: exp_mem[3]});
    tick(3);
    expect_drained("tx_busy");
  endtask

  task automatic test_errors;
    int s;
    send_byte(8'h7E, s); push_err(s);
    send_byte(8'hAA, s); send_byte(8'h10, s); push_err(s);
    send_byte(8'hAA, s); send_byte(8'h0F, s); send_byte(8'h55, s);
    push_wr(s, 8'h0F, 8'h55);
    send_byte(8'hBB, s); send_byte(8'h10, s); push_err(s);
    send_byte(8'hBB, s); send_byte(8'h0F, s); push_rd(s, 8'h0F, 1'b1);
    send_byte(8'h22, s); push_err(s);      // arrives in RD_WAIT
    tick(6);
    expect_drained("errors");
  endtask

  task automatic test_back_to_back;
    int s;
    send_byte(8'hAA, s); send_byte(8'h01, s); send_byte(8'h11, s); push_wr(s, 8'h01, 8'h11);
    send_byte(8'hAA, s); send_byte(8'h02, s); send_byte(8'h22, s); push_wr(s, 8'h02, 8'h22);
    send_byte(8'hBB, s); send_byte(8'h01, s); push_rd(s, 8'h01, 1'b1);
    tick(5);
    send_byte(8'hBB, s); send_byte(8'h02, s); push_rd(s, 8'h02, 1'b1);
    tick(6);
    expect_drained("back_to_back");
  endtask

  task automatic test_mid_reset;
    int s;
    send_byte(8'hAA, s); send_byte(8'h02, s);
    #3 CTRL_RST = 1'b0;
    #1;
    n_checks++;
    if ({RF_Addr, RF_WrData, RF_Wr_en, RF_Rd_en, TX_P_Data, TX_D_Valid, Cmd_Error} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h, required 0",
               {RF_Addr, RF_WrData, RF_Wr_en, RF_Rd_en, TX_P_Data, TX_D_Valid, Cmd_Error});
    end
    tick(2);
    CTRL_RST = 1'b1;
    tick(5);
    send_byte(8'hAA, s); send_byte(8'h02, s); send_byte(8'h99, s);
    push_wr(s, 8'h02, 8'h99);
    tick(4);
    expect_drained("mid_reset");
    n_checks++;
    if (rf_mem[2] !== 8'h99) begin
      n_fail++;
      $display("FAIL mid_reset_rf_content: got %02h, required 99", rf_mem[2]);
    end
  endtask

  task automatic test_timeout;
    int s;
    send_byte(8'hAA, s);
`ifdef CTRL_TIMEOUT_EN
    push_err(s + 16);
    tick(20);
    send_byte(8'hAA, s);
`else
    tick(100);
`endif
    send_byte(8'h04, s); send_byte(8'h4D, s); push_wr(s, 8'h04, 8'h4D);
    tick(4);
    expect_drained("timeout");
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_tx_busy;
    test_errors;
    test_back_to_back;
    test_mid_reset;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
